// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues sequential fetch PCs to a 1-cycle-latency
// instruction memory, buffers {pc, instr} pairs in a DEPTH-entry FIFO and
// hands them to decode over valid/ready. A redirect flushes everything in
// flight and refetches from the (word-aligned) target. The first target
// entry reaches decode three cycles after the redirect cycle.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [31:0]                  imem_pc,
    output logic                         imem_req,
    input  logic [31:0]                  imem_instr,
    input  logic                         imem_valid,
    input  logic                         redirect,
    input  logic [31:0]                  redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_pc,
    output logic [31:0]                  out_instr,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic          inflight;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];
    logic          push;
    logic          pop;
    logic [CW:0]   credit;

    // Issue credit, handshake decode and head presentation
    always_comb begin
        credit    = (CW+1)'(count) + (CW+1)'(inflight);
        imem_pc   = fetch_pc;
        imem_req  = rst && !redirect && (credit < (CW+1)'(DEPTH))
                    && !(inflight && !imem_valid);
        out_valid = (count != '0);
        push      = inflight && imem_valid && !redirect;
        pop       = out_valid && out_ready && !redirect;
        out_pc    = out_valid ? mem_pc[rptr]    : '0;
        out_instr = out_valid ? mem_instr[rptr] : '0;
    end

    // FIFO storage; contents are don't-care while the slot is unoccupied
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wptr]    <= req_pc;
            mem_instr[wptr] <= imem_instr;
        end
    end

    // Fetch PC, in-flight tracking, FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
        end else begin
            if (push)
                wptr <= wptr + PW'(1);
            if (pop)
                rptr <= rptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);

            if (imem_req) begin
                req_pc   <= fetch_pc;
                inflight <= 1'b1;
                fetch_pc <= fetch_pc + 32'd4;
            end else begin
                inflight <= 1'b0;
                // Unserved request: rewind so the same PC is reissued
                if (inflight && !imem_valid)
                    fetch_pc <= req_pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized self-checking bench for fetch_queue against a queue-based
// reference model of the fetch stage.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [31:0] imem_pc;
    logic        imem_req;
    logic [31:0] imem_instr;
    logic        imem_valid;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int unsigned n_checks;
    int unsigned n_errors;

    // Reference model state
    logic [63:0] q[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_req_pc;
    bit          m_inflight;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_pc    (imem_pc),
        .imem_req   (imem_req),
        .imem_instr (imem_instr),
        .imem_valid (imem_valid),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_instr  (out_instr),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_fetch_pc = 32'h0;
        m_req_pc   = 32'h0;
        m_inflight = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_count"}, 32'(count),     32'd0);
        check({tag, "_req"},   32'(imem_req),  32'd0);
        check({tag, "_pc"},    out_pc,         32'd0);
        check({tag, "_instr"}, out_instr,      32'd0);
    endtask

    initial begin
        int unsigned p_valid, p_ready, p_redir;
        bit          exp_req, do_pop;

        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b0;
        imem_instr  = '0;
        imem_valid  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;
        model_reset();

        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            // Phase-dependent traffic mix (percentages)
            if (cyc < 300)       begin p_valid = 100; p_ready = 100; p_redir = 0;  end
            else if (cyc < 600)  begin p_valid = 100; p_ready = 10;  p_redir = 1;  end
            else if (cyc < 1200) begin p_valid = 70;  p_ready = 80;  p_redir = 3;  end
            else                 begin p_valid = 85;  p_ready = 60;  p_redir = 6;  end

            if (cyc == 2000) begin
                // Asynchronous reset between edges, mid-stream
                #2 rst = 1'b0;
                #1;
                check_reset_outputs("async_rst");
                model_reset();
                @(posedge clk); #1;
                rst = 1'b1;
            end

            imem_valid  = ($urandom_range(99) < p_valid);
            imem_instr  = $urandom;
            out_ready   = ($urandom_range(99) < p_ready);
            redirect    = ($urandom_range(99) < p_redir);
            redirect_pc = (($urandom_range(3) == 0) ? 32'h100 : $urandom) | 32'($urandom_range(3));
            #1;

            exp_req = !redirect && (q.size() + 32'(m_inflight) < DEPTH)
                      && !(m_inflight && !imem_valid);
            check("imem_req",  32'(imem_req),  32'(exp_req));
            check("count",     32'(count),     32'(q.size()));
            check("out_valid", 32'(out_valid), 32'(q.size() != 0));
            if (exp_req)
                check("imem_pc", imem_pc, m_fetch_pc);
            if (q.size() != 0) begin
                check("out_pc",    out_pc,    q[0][63:32]);
                check("out_instr", out_instr, q[0][31:0]);
            end

            // Advance the model by one clock
            if (redirect) begin
                q.delete();
                m_inflight = 0;
                m_fetch_pc = redirect_pc & ~32'h3;
            end else begin
                do_pop = (q.size() != 0) && out_ready;
                if (do_pop)
                    void'(q.pop_front());
                if (m_inflight && imem_valid)
                    q.push_back({m_req_pc, imem_instr});
                if (exp_req) begin
                    m_req_pc   = m_fetch_pc;
                    m_inflight = 1;
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end else begin
                    if (m_inflight && !imem_valid)
                        m_fetch_pc = m_req_pc;
                    m_inflight = 0;
                end
            end

            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
